// File: rtl/currency_accumulator.sv
// -----------------------------------------------------------------------------
// currency_accumulator
//
// Coin-acceptance and credit stage that sits directly upstream of the vending
// main controller. It latches the selected item's price, adds inserted coins
// into a credit register and raises currency_avail once the credit covers the
// price. After a dispense, a cancel, a configuration abort or an escrow
// timeout it returns the change or a full refund as a one-cycle pulse.
//
// Optional feature:
//   ESCROW_TIMEOUT_EN  - when defined, COLLECT gives up after TIMEOUT_CYCLES
//                        consecutive cycles without an accepted coin and
//                        refunds the credit. When undefined, COLLECT waits
//                        indefinitely and no counter is built.
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - asynchronous, active-high reset
//   cfg_mode       - configuration mode; aborts and refunds, top priority
//   price_valid    - one-cycle strobe, item_price is valid (IDLE only)
//   item_price     - price of the selected item
//   coin_valid     - one-cycle strobe for one inserted coin
//   coin_type      - coin code: 00=5, 01=10, 10=20, 11=50 units
//   cancel         - user cancel, honoured in COLLECT only
//   dispense_valid - dispenser delivered the item, honoured in PAID only
//   currency_avail - credit >= price (high throughout PAID)
//   credit         - current credit
//   coin_reject    - one-cycle pulse, the coin sampled last cycle was returned
//   change_valid   - one-cycle pulse, change_amount is valid
//   change_amount  - change or refund value, holds outside the pulse
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module currency_accumulator #(
    parameter int CREDIT_W       = 10,
    parameter int MAX_CREDIT     = 500,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_mode,
    input  logic                price_valid,
    input  logic [CREDIT_W-1:0] item_price,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    input  logic                dispense_valid,
    output logic                currency_avail,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_PAID    = 2'd2;
    localparam logic [1:0] ST_CHANGE  = 2'd3;

    // Sums are one bit wider than the credit so an overflowing coin is seen
    // as "too large" rather than wrapping to a small value.
    localparam int                SUM_W        = CREDIT_W + 1;
    localparam logic [SUM_W-1:0]  MAX_CREDIT_W = SUM_W'(MAX_CREDIT);

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W-1:0] v;
        case (code)
            2'b00:   v = CREDIT_W'(5);
            2'b01:   v = CREDIT_W'(10);
            2'b10:   v = CREDIT_W'(20);
            default: v = CREDIT_W'(50);
        endcase
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]          state_q,          state_d;
    logic [CREDIT_W-1:0] price_q,          price_d;
    logic [CREDIT_W-1:0] credit_q,         credit_d;
    logic                currency_avail_q, currency_avail_d;
    logic                coin_reject_q,    coin_reject_d;
    logic                change_valid_q,   change_valid_d;
    logic [CREDIT_W-1:0] change_amount_q,  change_amount_d;

`ifdef ESCROW_TIMEOUT_EN
    localparam int                CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic             timeout_hit;
`endif

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic [SUM_W-1:0] coin_sum;
    logic             coin_fits;
    logic             coin_covers;
    logic             price_in_range;
    logic             credit_nonzero;

    assign coin_sum       = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};
    assign coin_fits      = (coin_sum <= MAX_CREDIT_W);
    assign coin_covers    = (coin_sum >= {1'b0, price_q});
    assign price_in_range = ({1'b0, item_price} <= MAX_CREDIT_W);
    assign credit_nonzero = (credit_q != '0);

`ifdef ESCROW_TIMEOUT_EN
    assign timeout_hit = (timeout_cnt_q == TIMEOUT_LAST);
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic                coin_accept;
    logic                enter_change;
    logic [CREDIT_W-1:0] change_value;

    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        state_d         = state_q;
        price_d         = price_q;
        credit_d        = credit_q;
        change_amount_d = change_amount_q;
        coin_accept     = 1'b0;
        enter_change    = 1'b0;
        change_value    = '0;

        if (cfg_mode) begin
            // Abort from any state. In CHANGE the credit is already cleared,
            // so a held cfg_mode never pays the same refund twice.
            if (credit_nonzero) begin
                enter_change = 1'b1;
                change_value = credit_q;
            end else begin
                state_d  = ST_IDLE;
                price_d  = '0;
                credit_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (price_valid && price_in_range) begin
                        price_d = item_price;
                        state_d = (item_price == '0) ? ST_PAID : ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (cancel) begin
                        // Cancel beats a simultaneous coin; that coin is returned.
                        enter_change = 1'b1;
                        change_value = credit_q;
                    end else if (coin_valid && coin_fits) begin
                        coin_accept = 1'b1;
                        credit_d    = coin_sum[CREDIT_W-1:0];
                        if (coin_covers) begin
                            state_d = ST_PAID;
                        end
`ifdef ESCROW_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        if (credit_nonzero) begin
                            enter_change = 1'b1;
                            change_value = credit_q;
                        end else begin
                            state_d = ST_IDLE;
                            price_d = '0;
                        end
`endif
                    end
                end

                ST_PAID: begin
                    // Credit >= price holds throughout PAID, so no underflow.
                    if (dispense_valid) begin
                        enter_change = 1'b1;
                        change_value = credit_q - price_q;
                    end
                end

                default: begin
                    // ST_CHANGE: the pulse is already on the outputs.
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Credit and price are cleared on entry to CHANGE so the pulse cycle
        // already shows the emptied escrow.
        if (enter_change) begin
            state_d         = ST_CHANGE;
            change_amount_d = change_value;
            credit_d        = '0;
            price_d         = '0;
        end
    end

    // Output registers are computed from the next state so that, e.g.,
    // currency_avail rises together with the credit that satisfies the price.
    always_comb begin
        currency_avail_d = (state_d == ST_PAID);
        change_valid_d   = (state_d == ST_CHANGE);
        coin_reject_d    = coin_valid && !coin_accept;
    end

`ifdef ESCROW_TIMEOUT_EN
    // Counter restarts on entry to COLLECT and on every accepted coin; a
    // rejected coin does not count as activity.
    always_comb begin
        timeout_cnt_d = '0;
        if (state_d == ST_COLLECT && state_q == ST_COLLECT && !coin_accept) begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Sequential
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // the values from before this edge, independent of statement order.
        if (rst) begin
            state_q          <= ST_IDLE;
            price_q          <= '0;
            credit_q         <= '0;
            currency_avail_q <= 1'b0;
            coin_reject_q    <= 1'b0;
            change_valid_q   <= 1'b0;
            change_amount_q  <= '0;
        end else begin
            state_q          <= state_d;
            price_q          <= price_d;
            credit_q         <= credit_d;
            currency_avail_q <= currency_avail_d;
            coin_reject_q    <= coin_reject_d;
            change_valid_q   <= change_valid_d;
            change_amount_q  <= change_amount_d;
        end
    end

`ifdef ESCROW_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`endif

    assign currency_avail = currency_avail_q;
    assign credit         = credit_q;
    assign coin_reject    = coin_reject_q;
    assign change_valid   = change_valid_q;
    assign change_amount  = change_amount_q;

endmodule
